// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with a destination-reservation scoreboard.
// Optional same-cycle write-through on reads is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned LED_SEL  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_stall,
  output logic [ADDR_W:0]          busy_cnt,
  output logic [7:0]               reg_led_o
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam bit ZeroEn = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LedIdx = ADDR_W'(LED_SEL);

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ok, rsv_ok, cnt_inc, cnt_dec;

  assign rsv_stall = rsv_en & busy_q[rsv_addr] & ~(wr_en & (wr_addr == rsv_addr));
  assign rsv_ok    = rsv_en & ~rsv_stall & ~(ZeroEn & (rsv_addr == '0));
  assign wr_ok     = wr_en & ~(ZeroEn & (wr_addr == '0));

  // Reservation is applied after the write clear so it wins on a shared address.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[wr_addr] = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  // A write clearing the same address that is re-reserved leaves the count untouched.
  assign cnt_inc = rsv_ok & ~busy_q[rsv_addr];
  assign cnt_dec = wr_ok & busy_q[wr_addr] & ~(rsv_ok & (rsv_addr == wr_addr));

  always_comb begin
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end
`endif
      if (ZeroEn && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) rd_data[k*DATA_W +: DATA_W] = '0;
      rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  assign busy_cnt  = cnt_q;
  assign reg_led_o = regs_q[LedIdx][DATA_W-1 -: 8];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default-parameter instance plus a narrow 3-port instance.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_rsv_stall;
  logic [5:0]  a_busy_cnt;
  logic [7:0]  a_led;

  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_rsv_en;
  logic [2:0]  b_rsv_addr;
  logic        b_rsv_stall;
  logic [3:0]  b_busy_cnt;
  logic [7:0]  b_led;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_param u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (a_rd_addr),
    .rd_data   (a_rd_data),
    .rd_busy   (a_rd_busy),
    .wr_en     (a_wr_en),
    .wr_addr   (a_wr_addr),
    .wr_data   (a_wr_data),
    .rsv_en    (a_rsv_en),
    .rsv_addr  (a_rsv_addr),
    .rsv_stall (a_rsv_stall),
    .busy_cnt  (a_busy_cnt),
    .reg_led_o (a_led)
  );

  regfile_param #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .NUM_RD  (3),
    .LED_SEL (2)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (b_rd_addr),
    .rd_data   (b_rd_data),
    .rd_busy   (b_rd_busy),
    .wr_en     (b_wr_en),
    .wr_addr   (b_wr_addr),
    .wr_data   (b_wr_data),
    .rsv_en    (b_rsv_en),
    .rsv_addr  (b_rsv_addr),
    .rsv_stall (b_rsv_stall),
    .busy_cnt  (b_busy_cnt),
    .reg_led_o (b_led)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    a_rd_addr  = '0;
    a_wr_en    = 1'b0;
    a_wr_addr  = '0;
    a_wr_data  = '0;
    a_rsv_en   = 1'b0;
    a_rsv_addr = '0;
    b_rd_addr  = '0;
    b_wr_en    = 1'b0;
    b_wr_addr  = '0;
    b_wr_data  = '0;
    b_rsv_en   = 1'b0;
    b_rsv_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    a_rd_addr = {5'd9, 5'd4};
    #1;
    chk("reset_rd_data", a_rd_data, 64'h0);
    chk("reset_rd_busy", a_rd_busy, 2'b00);
    chk("reset_stall", a_rsv_stall, 1'b0);
    chk("reset_cnt", a_busy_cnt, 6'd0);
    chk("reset_led", a_led, 8'h00);

    // Basic write then read on both ports
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    tick();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd5, 5'd5};
    #1;
    chk("wr5_port0", a_rd_data[31:0], 32'hDEADBEEF);
    chk("wr5_port1", a_rd_data[63:32], 32'hDEADBEEF);
    chk("wr5_cnt", a_busy_cnt, 6'd0);

    // Same-cycle write and read of address 3
    a_rd_addr = {5'd5, 5'd3};
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h12345678;
    #1;
    chk("bypass_rd3", a_rd_data[31:0], Byp ? 32'h12345678 : 32'h0);
    chk("bypass_other", a_rd_data[63:32], 32'hDEADBEEF);
    tick();
    a_wr_en = 1'b0;
    #1;
    chk("after_wr3", a_rd_data[31:0], 32'h12345678);

    // Register 0 is hardwired
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_stall", a_rsv_stall, 1'b0);
    chk("zero_rd_wcycle", a_rd_data[31:0], 32'h0);
    tick();
    a_wr_en = 1'b0; a_rsv_en = 1'b0;
    #1;
    chk("zero_rd", a_rd_data, 64'h0);
    chk("zero_busy", a_rd_busy, 2'b00);
    chk("zero_cnt", a_busy_cnt, 6'd0);
    chk("zero_led", a_led, 8'h00);

    // WAW hazard on address 7
    a_rd_addr = {5'd7, 5'd0};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
    #1;
    chk("rsv7_first_stall", a_rsv_stall, 1'b0);
    tick();
    chk("rsv7_cnt", a_busy_cnt, 6'd1);
    chk("rsv7_busy", a_rd_busy, 2'b10);
    chk("rsv7_again_stall", a_rsv_stall, 1'b1);
    tick();
    chk("rsv7_stalled_cnt", a_busy_cnt, 6'd1);
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h00000077;
    #1;
    chk("wr_rsv7_stall", a_rsv_stall, 1'b0);
    chk("wr_rsv7_busy_nofwd", a_rd_busy, 2'b10);
    tick();
    a_wr_en = 1'b0; a_rsv_en = 1'b0;
    #1;
    chk("wr_rsv7_cnt", a_busy_cnt, 6'd1);
    chk("wr_rsv7_busy", a_rd_busy, 2'b10);
    chk("wr_rsv7_data", a_rd_data[63:32], 32'h00000077);

    // Plain write releases the reservation
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h00000078;
    tick();
    a_wr_en = 1'b0;
    #1;
    chk("release7_cnt", a_busy_cnt, 6'd0);
    chk("release7_busy", a_rd_busy, 2'b00);

    // Unreserved write leaves count alone
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hCAFE0009;
    tick();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd9, 5'd7};
    #1;
    chk("unrsv_cnt", a_busy_cnt, 6'd0);
    chk("unrsv_data", a_rd_data, {32'hCAFE0009, 32'h00000078});

    // Set one bit while clearing another: net zero change
    a_rsv_en = 1'b1; a_rsv_addr = 5'd10;
    tick();
    a_rsv_addr = 5'd11;
    a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h0000000A;
    tick();
    a_rsv_en = 1'b0; a_wr_en = 1'b0;
    a_rd_addr = {5'd11, 5'd10};
    #1;
    chk("swap_cnt", a_busy_cnt, 6'd1);
    chk("swap_busy", a_rd_busy, 2'b10);

    // Sweep reservations 1..20 (11 already busy, so it stalls)
    for (int i = 1; i <= 20; i++) begin
      a_rsv_en = 1'b1; a_rsv_addr = 5'(i);
      tick();
    end
    chk("sweep_cnt", a_busy_cnt, 6'd20);
    chk("sweep_busy", a_rd_busy, 2'b11);

    // Reset mid-sequence beats a pending reservation and write
    a_rsv_addr = 5'd21;
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h55555555;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_wr_en = 1'b0;
    a_rsv_addr = 5'd1;
    a_rd_addr = {5'd21, 5'd1};
    #1;
    chk("rst_cnt", a_busy_cnt, 6'd0);
    chk("rst_busy", a_rd_busy, 2'b00);
    chk("rst_stall", a_rsv_stall, 1'b0);
    chk("rst_rd", a_rd_data, 64'h0);
    a_rsv_en = 1'b0;
    a_rd_addr = {5'd3, 5'd5};
    #1;
    chk("rst_wr_blocked", a_rd_data, 64'h0);

    // Narrow three-port instance with LED tap on register 2
    b_wr_en = 1'b1; b_wr_addr = 3'd2; b_wr_data = 16'hAB00;
    tick();
    b_wr_en = 1'b0;
    b_rd_addr = {3'd2, 3'd2, 3'd2};
    #1;
    chk("b_led", b_led, 8'hAB);
    chk("b_ports", b_rd_data, {16'hAB00, 16'hAB00, 16'hAB00});
    b_rsv_en = 1'b1; b_rsv_addr = 3'd2;
    tick();
    b_rsv_en = 1'b0;
    #1;
    chk("b_busy", b_rd_busy, 3'b111);
    chk("b_cnt", b_busy_cnt, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
